alu_ctrl_stage: RTL and testbench

- Producer side of the ALU control interface.
- Decodes the main-decoder ALUOp and the R-type funct/shamt fields into the 4-bit ALU control code and the shift-amount operand the ALU consumes.
- Registers the result into the ID/EX boundary with stall/flush handling.
- Detects illegal R-type functs, enters a trap state, and keeps a saturating illegal-op count for debug.

---
 rtl/alu_ctrl_stage.sv | 139 +++++++++++++
 tb/tb_alu_ctrl_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_stage.sv
// ALU control producer: decodes ALUOp/funct/shamt and registers the result into ID/EX,
// with stall/flush handling, an illegal-funct trap state and a saturating illegal counter.
module alu_ctrl_stage #(
  parameter int CNT_W   = 8,
  parameter bit TRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_control,
  output logic [31:0]      ex_shamt,
  output logic             ex_illegal,
  output logic             trapped,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [4:0]       shamt_q, shamt_d;
  logic             illegal_q, illegal_d;
  logic             trapped_q, trapped_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [3:0]       dec_ctrl_s;
  logic             dec_illegal_s;

  // ALU control decode of the incoming ID-stage fields
  always_comb begin
    dec_ctrl_s    = 4'b0000;
    dec_illegal_s = 1'b0;
    case (alu_op)
      2'b00: dec_ctrl_s = 4'b0010;
      2'b01: dec_ctrl_s = 4'b0110;
      2'b11: dec_ctrl_s = 4'b0111;
      2'b10: begin
        case (funct)
          6'b100000: dec_ctrl_s = 4'b0010;
          6'b100010: dec_ctrl_s = 4'b0110;
          6'b100100: dec_ctrl_s = 4'b0000;
          6'b100101: dec_ctrl_s = 4'b0001;
          6'b101010: dec_ctrl_s = 4'b0111;
          6'b000000: dec_ctrl_s = 4'b0100;
          6'b000010: dec_ctrl_s = 4'b0101;
          default: begin
            dec_ctrl_s    = 4'b0000;
            dec_illegal_s = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctrl_s    = 4'b0000;
        dec_illegal_s = 1'b0;
      end
    endcase
  end

  // Next-state for the ID/EX registers, trap state and counter (flush > stall > load)
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    shamt_d   = shamt_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    if (flush) begin
      state_d   = ST_RUN;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      ctrl_d    = 4'b0000;
    end else if (stall) begin
      state_d = state_q;
    end else if (state_q == ST_TRAP) begin
      // Trapped: nothing is accepted until a flush
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else begin
      valid_d   = id_valid;
      ctrl_d    = dec_ctrl_s;
      shamt_d   = shamt;
      illegal_d = id_valid & dec_illegal_s;
      if (id_valid && dec_illegal_s) begin
        if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + CNT_W'(1'b1);
        end else begin
          count_d = count_q;
        end
        if (TRAP_EN) begin
          state_d = ST_TRAP;
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        count_d = count_q;
      end
    end
    trapped_d = (state_d == ST_TRAP);
  end

  // State and ID/EX register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      valid_q   <= 1'b0;
      ctrl_q    <= 4'b0000;
      shamt_q   <= 5'b00000;
      illegal_q <= 1'b0;
      trapped_q <= 1'b0;
      count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      shamt_q   <= shamt_d;
      illegal_q <= illegal_d;
      trapped_q <= trapped_d;
      count_q   <= count_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_alu_control = ctrl_q;
  assign ex_shamt       = {21'b0, shamt_q, 6'b0};
  assign ex_illegal     = illegal_q;
  assign trapped        = trapped_q;
  assign illegal_count  = count_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed self-checking bench for alu_ctrl_stage (default trap config plus a TRAP_EN=0, CNT_W=2 copy).
module tb_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, stall, flush;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;

  logic        ex_valid, ex_illegal, trapped;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_shamt;
  logic [7:0]  illegal_count;

  logic        ex_valid2, ex_illegal2, trapped2;
  logic [3:0]  ex_alu_control2;
  logic [31:0] ex_shamt2;
  logic [1:0]  illegal_count2;

  int tests = 0;
  int fails = 0;

  alu_ctrl_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .alu_op(alu_op), .funct(funct),
    .shamt(shamt), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_control(ex_alu_control), .ex_shamt(ex_shamt), .ex_illegal(ex_illegal),
    .trapped(trapped), .illegal_count(illegal_count)
  );

  alu_ctrl_stage #(.CNT_W(2), .TRAP_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .alu_op(alu_op), .funct(funct),
    .shamt(shamt), .stall(stall), .flush(flush), .ex_valid(ex_valid2),
    .ex_alu_control(ex_alu_control2), .ex_shamt(ex_shamt2), .ex_illegal(ex_illegal2),
    .trapped(trapped2), .illegal_count(illegal_count2)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle for sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh);
    id_valid = v; alu_op = op; funct = f; shamt = sh;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'b00, 6'b000000, 5'd0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({ex_valid, ex_alu_control, ex_shamt, ex_illegal, trapped, illegal_count} !== 47'd0) begin
      fails++;
      $display("FAIL reset: valid=%b ctrl=%b shamt=%h ill=%b trap=%b cnt=%0d, expected all zero",
               ex_valid, ex_alu_control, ex_shamt, ex_illegal, trapped, illegal_count);
    end
  endtask

  task automatic test_first_load();
    drive(1'b1, 2'b10, 6'b100010, 5'd0);
    step();
    tests++;
    if ({ex_valid, ex_alu_control, ex_illegal} !== 6'b1_0110_0) begin
      fails++;
      $display("FAIL first_sub: valid=%b ctrl=%b ill=%b, expected 1 0110 0", ex_valid, ex_alu_control, ex_illegal);
    end
  endtask

  task automatic test_decode();
    logic [1:0]  ops   [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [5:0]  fns   [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                6'b000000, 6'b000010, 6'b111111, 6'b000001, 6'b110011};
    logic [3:0]  exp_c [10] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                                4'b0100, 4'b0101, 4'b0010, 4'b0110, 4'b0111};
    logic [4:0]  shs   [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31, 5'd16, 5'd7, 5'd0, 5'd0, 5'd1};
    logic [31:0] exp_s [10] = '{32'h0, 32'h40, 32'h80, 32'hC0, 32'h7C0,
                                32'h400, 32'h1C0, 32'h0, 32'h0, 32'h40};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ops[i], fns[i], shs[i]);
      step();
      tests++;
      if ({ex_valid, ex_alu_control, ex_shamt, ex_illegal} !== {1'b1, exp_c[i], exp_s[i], 1'b0}) begin
        fails++;
        $display("FAIL decode[%0d]: valid=%b ctrl=%b shamt=%h ill=%b, expected 1 %b %h 0",
                 i, ex_valid, ex_alu_control, ex_shamt, ex_illegal, exp_c[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_trap();
    do_reset();
    drive(1'b1, 2'b10, 6'b111111, 5'd0);
    step();
    tests++;
    if ({ex_valid, ex_illegal, trapped, illegal_count, ex_alu_control} !== {3'b111, 8'd1, 4'b0000}) begin
      fails++;
      $display("FAIL trap_enter: valid=%b ill=%b trap=%b cnt=%0d ctrl=%b, expected 1 1 1 1 0000",
               ex_valid, ex_illegal, trapped, illegal_count, ex_alu_control);
    end
    drive(1'b1, 2'b10, 6'b100000, 5'd0);
    step();
    tests++;
    if ({ex_valid, ex_illegal, trapped, illegal_count} !== {3'b001, 8'd1}) begin
      fails++;
      $display("FAIL trap_hold_legal: valid=%b ill=%b trap=%b cnt=%0d, expected 0 0 1 1",
               ex_valid, ex_illegal, trapped, illegal_count);
    end
    drive(1'b1, 2'b10, 6'b111110, 5'd0);
    step();
    tests++;
    if ({ex_illegal, trapped, illegal_count} !== {2'b01, 8'd1}) begin
      fails++;
      $display("FAIL trap_no_count: ill=%b trap=%b cnt=%0d, expected 0 1 1", ex_illegal, trapped, illegal_count);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++;
    if ({ex_valid, trapped, illegal_count} !== {2'b00, 8'd1}) begin
      fails++;
      $display("FAIL trap_flush: valid=%b trap=%b cnt=%0d, expected 0 0 1", ex_valid, trapped, illegal_count);
    end
    drive(1'b1, 2'b10, 6'b100101, 5'd0);
    step();
    tests++;
    if ({ex_valid, ex_alu_control, ex_illegal, trapped} !== 7'b1_0001_00) begin
      fails++;
      $display("FAIL trap_resume: valid=%b ctrl=%b ill=%b trap=%b, expected 1 0001 0 0",
               ex_valid, ex_alu_control, ex_illegal, trapped);
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive(1'b1, 2'b10, 6'b000000, 5'd9);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(1'b1, 2'b10, 6'b111111, 5'd3);
      else        drive(i[0], 2'b01, 6'b100101, 5'(i + 1));
      step();
      tests++;
      if ({ex_valid, ex_alu_control, ex_shamt, ex_illegal, trapped, illegal_count}
          !== {1'b1, 4'b0100, 32'h240, 2'b00, 8'd0}) begin
        fails++;
        $display("FAIL stall[%0d]: valid=%b ctrl=%b shamt=%h ill=%b trap=%b cnt=%0d, expected 1 0100 240 0 0 0",
                 i, ex_valid, ex_alu_control, ex_shamt, ex_illegal, trapped, illegal_count);
      end
    end
    flush = 1'b1;
    step();
    tests++;
    if ({ex_valid, ex_alu_control, ex_illegal, trapped, illegal_count} !== {7'b0_0000_00, 8'd0}) begin
      fails++;
      $display("FAIL stall_flush: valid=%b ctrl=%b ill=%b trap=%b cnt=%0d, expected 0 0000 0 0 0",
               ex_valid, ex_alu_control, ex_illegal, trapped, illegal_count);
    end
    stall = 1'b0;
    drive(1'b1, 2'b10, 6'b111111, 5'd0);
    step();
    flush = 1'b0;
    tests++;
    if ({ex_valid, ex_illegal, trapped, illegal_count} !== {3'b000, 8'd0}) begin
      fails++;
      $display("FAIL flush_illegal: valid=%b ill=%b trap=%b cnt=%0d, expected 0 0 0 0",
               ex_valid, ex_illegal, trapped, illegal_count);
    end
  endtask

  task automatic test_saturate_no_trap();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b10, 6'b010101, 5'd0);
      step();
      tests++;
      if ({ex_valid2, ex_illegal2, trapped2, illegal_count2} !== {3'b110, exp_cnt[i]}) begin
        fails++;
        $display("FAIL saturate[%0d]: valid=%b ill=%b trap=%b cnt=%0d, expected 1 1 0 %0d",
                 i, ex_valid2, ex_illegal2, trapped2, illegal_count2, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 2'b10, 6'b111111, 5'd5);
    step();
    tests++;
    if ({ex_valid, trapped} !== 2'b11) begin
      fails++;
      $display("FAIL async_pre: valid=%b trap=%b, expected 1 1", ex_valid, trapped);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ex_valid, ex_alu_control, ex_shamt, ex_illegal, trapped, illegal_count} !== 47'd0) begin
      fails++;
      $display("FAIL async_reset: valid=%b ctrl=%b shamt=%h ill=%b trap=%b cnt=%0d, expected all zero",
               ex_valid, ex_alu_control, ex_shamt, ex_illegal, trapped, illegal_count);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'b00, 6'b000000, 5'd0);
    #1;
    test_reset();
    test_first_load();
    test_decode();
    test_trap();
    test_stall_flush();
    test_saturate_no_trap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
